// File: rtl/serial_frame_ctrl_if.sv
// Byte-stream interface of the serial framing controller: serial bit input, control strobes,
// and the valid/ready byte output with its sideband tags and status.
interface serial_frame_ctrl_if;
  logic       bit_valid;
  logic       data_in;
  logic       abort;
  logic       clr_ovf;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;
  logic       byte_first;
  logic       byte_last;
  logic       locked;
  logic       overflow;

  // master: the framing controller itself
  modport master (
    input  bit_valid,
    input  data_in,
    input  abort,
    input  clr_ovf,
    input  byte_ready,
    output byte_out,
    output byte_valid,
    output byte_first,
    output byte_last,
    output locked,
    output overflow
  );

  // slave: serial front end plus byte consumer
  modport slave (
    output bit_valid,
    output data_in,
    output abort,
    output clr_ovf,
    output byte_ready,
    input  byte_out,
    input  byte_valid,
    input  byte_first,
    input  byte_last,
    input  locked,
    input  overflow
  );
endinterface

// File: rtl/serial_frame_ctrl.sv
// Serial framing controller: hunts the bit stream for a sync byte, then slices a fixed number
// of payload bytes and hands each to a one-entry valid/ready output register.
module serial_frame_ctrl #(
  parameter logic [7:0]  SyncByte = 8'hA5,
  parameter int unsigned FrameLen = 12
) (
  input logic              clk,
  input logic              rst_n,
  serial_frame_ctrl_if.master bus
);

  localparam int unsigned CntW = (FrameLen > 1) ? $clog2(FrameLen) : 1;

  if (FrameLen < 1 || FrameLen > 256) begin : g_bad_len
    $error("serial_frame_ctrl: FrameLen must be in 1..256");
  end

  typedef enum logic [0:0] {StHunt, StPayload} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sh_q, sh_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [CntW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [7:0]        nxt;
  logic              is_last;
  logic              complete;

  logic [7:0]        out_q, out_d;
  logic              valid_q, valid_d;
  logic              first_q, first_d;
  logic              last_q, last_d;
  logic              ovf_q, ovf_d;
  logic              load;
  logic              drop;

  assign is_last = (byte_cnt_q == CntW'(FrameLen - 1));

  always_comb begin
    nxt        = {sh_q[6:0], bus.data_in};
    state_d    = state_q;
    sh_d       = sh_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    complete   = 1'b0;

    // Abort outranks any bit arriving in the same cycle; that bit is discarded.
    if (bus.abort) begin
      state_d    = StHunt;
      sh_d       = '0;
      bit_cnt_d  = '0;
      byte_cnt_d = '0;
    end else if (bus.bit_valid) begin
      sh_d = nxt;
      unique case (state_q)
        StHunt: begin
          if (nxt == SyncByte) begin
            state_d    = StPayload;
            bit_cnt_d  = '0;
            byte_cnt_d = '0;
          end
        end
        StPayload: begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            complete = 1'b1;
            if (is_last) begin
              state_d    = StHunt;
              sh_d       = '0;
              bit_cnt_d  = '0;
              byte_cnt_d = '0;
            end else begin
              byte_cnt_d = byte_cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_d = StHunt;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StHunt;
      sh_q       <= '0;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  // A completed byte loads only into a free or draining register; otherwise it is lost.
  assign load = complete && (!valid_q || bus.byte_ready);
  assign drop = complete && valid_q && !bus.byte_ready;

  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    if (load) begin
      out_d   = nxt;
      valid_d = 1'b1;
      first_d = (byte_cnt_q == '0);
      last_d  = is_last;
    end else if (valid_q && bus.byte_ready) begin
      valid_d = 1'b0;
    end

    if (drop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.byte_out   = out_q;
  assign bus.byte_valid = valid_q;
  assign bus.byte_first = first_q;
  assign bus.byte_last  = last_q;
  assign bus.overflow   = ovf_q;
  assign bus.locked     = (state_q == StPayload);

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: a FrameLen=12 instance checked through a byte scoreboard and a
// FrameLen=1 instance sharing the same serial stimulus.
module tb_serial_frame_ctrl;

  localparam int unsigned FL = 12;

  logic clk;
  logic rst_n;
  logic bv, din, abort, clr, rdy;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];

  serial_frame_ctrl_if ifa ();
  serial_frame_ctrl_if ifb ();

  assign ifa.bit_valid  = bv;
  assign ifa.data_in    = din;
  assign ifa.abort      = abort;
  assign ifa.clr_ovf    = clr;
  assign ifa.byte_ready = rdy;
  assign ifb.bit_valid  = bv;
  assign ifb.data_in    = din;
  assign ifb.abort      = abort;
  assign ifb.clr_ovf    = clr;
  assign ifb.byte_ready = 1'b1;

  serial_frame_ctrl #(.SyncByte(8'hA5), .FrameLen(FL)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifa.master)
  );

  serial_frame_ctrl #(.SyncByte(8'hA5), .FrameLen(1)) u_dut_one (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifb.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Byte accepted at the next posedge: compare {first,last,data} with the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && ifa.byte_valid && ifa.byte_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_extra_byte", 32'(exp_q.size()), 32'd1);
      end else begin
        check("sb_byte", {ifa.byte_first, ifa.byte_last, ifa.byte_out}, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b, input int gap);
    bv  = 1'b1;
    din = b;
    tick();
    bv  = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic send_raw(input logic [7:0] d, input int gap);
    for (int k = 7; k >= 0; k--) send_bit(d[k], gap);
  endtask

  task automatic send_payload(input logic [7:0] d, input int idx, input int gap, input bit keep);
    for (int k = 7; k >= 0; k--) begin
      if (k == 0 && keep) exp_q.push_back({idx == 0, idx == FL - 1, d});
      send_bit(d[k], gap);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bv = 1'b0; din = 1'b0; abort = 1'b0; clr = 1'b0; rdy = 1'b1;
    #3;
    check("rst_byte_out", ifa.byte_out, 8'h00);
    check("rst_valid", ifa.byte_valid, 1'b0);
    check("rst_first", ifa.byte_first, 1'b0);
    check("rst_last", ifa.byte_last, 1'b0);
    check("rst_locked", ifa.locked, 1'b0);
    check("rst_overflow", ifa.overflow, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // 1: junk bits, sync, 01..0C
    send_bit(1'b0, 1); send_bit(1'b1, 1); send_bit(1'b1, 1);
    @(negedge clk);
    check("t1_hunting", ifa.locked, 1'b0);
    send_raw(8'hA5, 1);
    @(negedge clk);
    check("t1_locked", ifa.locked, 1'b1);
    for (int i = 0; i < FL; i++) begin
      send_payload(8'(i + 1), i, 1, 1'b1);
      if (i == FL - 2) begin
        @(negedge clk);
        check("t1_locked_before_last", ifa.locked, 1'b1);
      end
    end
    @(negedge clk);
    check("t1_unlocked", ifa.locked, 1'b0);
    idle(3);
    check("t1_drain", 32'(exp_q.size()), 32'd0);

    // 2: sync byte inside payload is data
    send_raw(8'hA5, 1);
    for (int i = 0; i < FL; i++) send_payload((i == 3) ? 8'hA5 : 8'(8'h10 + i), i, 1, 1'b1);
    @(negedge clk);
    check("t2_unlocked", ifa.locked, 1'b0);
    idle(3);
    check("t2_drain", 32'(exp_q.size()), 32'd0);

    // 3: consumer stalls 20 cycles, slow bit rate
    rdy = 1'b0;
    fork
      begin
        send_raw(8'hA5, 4);
        for (int i = 0; i < FL; i++) send_payload(8'(8'h40 + i), i, 4, 1'b1);
      end
      begin
        int w = 0;
        while (!ifa.byte_valid && w < 400) begin
          @(negedge clk);
          w++;
        end
        check("t3_valid_seen", ifa.byte_valid, 1'b1);
        repeat (20) begin
          @(negedge clk);
          check("t3_hold_data", ifa.byte_out, 8'h40);
        end
        check("t3_hold_first", ifa.byte_first, 1'b1);
        check("t3_no_ovf", ifa.overflow, 1'b0);
        @(posedge clk);
        #1 rdy = 1'b1;
      end
    join
    idle(3);
    check("t3_no_ovf_end", ifa.overflow, 1'b0);
    check("t3_drain", 32'(exp_q.size()), 32'd0);

    // 4: second completion while stalled is dropped
    send_raw(8'hA5, 1);
    rdy = 1'b0;
    send_payload(8'h20, 0, 1, 1'b1);
    @(negedge clk);
    check("t4_no_ovf_yet", ifa.overflow, 1'b0);
    send_payload(8'h21, 1, 1, 1'b0);
    @(negedge clk);
    check("t4_ovf_set", ifa.overflow, 1'b1);
    check("t4_held", ifa.byte_out, 8'h20);
    rdy = 1'b1;
    for (int i = 2; i < FL; i++) send_payload(8'(8'h20 + i), i, 1, 1'b1);
    @(negedge clk);
    check("t4_unlocked", ifa.locked, 1'b0);
    check("t4_ovf_sticky", ifa.overflow, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    @(negedge clk);
    check("t4_ovf_clear", ifa.overflow, 1'b0);
    idle(2);
    check("t4_drain", 32'(exp_q.size()), 32'd0);

    // 5: abort mid byte 5, then a clean frame
    send_raw(8'hA5, 1);
    for (int i = 0; i < 5; i++) send_payload(8'(8'h30 + i), i, 1, 1'b1);
    for (int k = 0; k < 4; k++) send_bit(1'b1, 1);
    bv = 1'b1; din = 1'b1; abort = 1'b1;
    tick();
    bv = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("t5_unlocked", ifa.locked, 1'b0);
    idle(12);
    check("t5_no_partial", 32'(exp_q.size()), 32'd0);
    send_raw(8'hA5, 1);
    for (int i = 0; i < FL; i++) send_payload(8'(8'h50 + i), i, 1, 1'b1);
    idle(3);
    check("t5_drain", 32'(exp_q.size()), 32'd0);
    check("t5_no_ovf", ifa.overflow, 1'b0);

    // 6: asynchronous reset with a pending byte, then the single-byte-frame instance
    rdy = 1'b0;
    send_raw(8'hA5, 1);
    send_payload(8'h66, 0, 1, 1'b1);
    #2;
    check("t6_pending", ifa.byte_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_out", {ifa.byte_out, ifa.byte_valid, ifa.byte_first, ifa.byte_last,
                         ifa.locked, ifa.overflow}, 13'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rdy = 1'b1;
    @(negedge clk);
    check("t6_hunt_after_rst", ifa.locked, 1'b0);
    send_raw(8'hA5, 1);
    send_payload(8'h3C, 0, 1, 1'b1);
    @(negedge clk);
    check("t6_one_byte", {ifb.byte_valid, ifb.byte_first, ifb.byte_last, ifb.byte_out},
          {3'b111, 8'h3C});
    check("t6_one_unlocked", ifb.locked, 1'b0);
    idle(3);
    check("t6_drain", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
